// File: rtl/bhc_pkg.sv
// Shared encodings for the branch history controller's 2-bit saturating counters.
// Imported by sat_counter2 and branch_history_ctrl.
package bhc_pkg;

  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] SNT = 2'b00;
  localparam logic [CNT_W-1:0] WNT = 2'b01;
  localparam logic [CNT_W-1:0] WT  = 2'b10;
  localparam logic [CNT_W-1:0] ST  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_RST = WNT;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next state, purely combinational (0 latency, no flow control).
// Moves toward ST on taken and toward SNT on not-taken, holding at either end.
module sat_counter2
  import bhc_pkg::*;
(
  input  logic [CNT_W-1:0] cur,
  input  logic             taken,
  output logic [CNT_W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + 2'd1;
    end else begin
      if (cur != SNT) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_history_ctrl.sv
// PHT of 2-bit counters: 0-cycle lookup with same-cycle update bypass, registered 1-cycle redirect/correct pulses.
// ex_stall freezes updates and pulses; optional BHC_STATS_EN adds branch/mispredict counters.
module branch_history_ctrl
  import bhc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6,
  parameter int PC_LSB = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_predicted,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_predicted,
  input  logic            ex_actual,
  output logic            redirect,
  output logic            redirect_tgt,
  output logic            pred_correct
`ifdef BHC_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CNT_W-1:0] pht [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [CNT_W-1:0] ex_cur;
  logic [CNT_W-1:0] ex_nxt;
  logic             fire;
  logic             mispredict;
  logic             unused_pc_bits;

  assign if_idx = if_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign ex_idx = ex_pc[PC_LSB+IDX_W-1:PC_LSB];
  assign unused_pc_bits = ^{if_pc[XLEN-1:PC_LSB+IDX_W], if_pc[PC_LSB-1:0],
                            ex_pc[XLEN-1:PC_LSB+IDX_W], ex_pc[PC_LSB-1:0]};

  assign fire       = ex_valid & ~ex_stall;
  assign mispredict = ex_predicted ^ ex_actual;
  assign ex_cur     = pht[ex_idx];

  sat_counter2 u_sat (
    .cur   (ex_cur),
    .taken (ex_actual),
    .nxt   (ex_nxt)
  );

  // Same-cycle update to the looked-up entry: fetch sees the value being written.
  assign if_predicted = (fire && (if_idx == ex_idx)) ? ex_nxt[1] : pht[if_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_RST;
    end else if (fire) begin
      pht[ex_idx] <= ex_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect     <= 1'b0;
      pred_correct <= 1'b0;
      redirect_tgt <= 1'b0;
    end else begin
      redirect     <= fire & mispredict;
      pred_correct <= fire & ~mispredict;
      if (fire) redirect_tgt <= ~(~ex_predicted & ex_actual);
    end
  end

`ifdef BHC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else if (fire) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_history_ctrl.sv
// Directed testbench for branch_history_ctrl; stats checks compile in when BHC_STATS_EN is defined.
module tb_branch_history_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_predicted;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic        ex_predicted;
  logic        ex_actual;
  logic        redirect;
  logic        redirect_tgt;
  logic        pred_correct;
`ifdef BHC_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_history_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .if_pc        (if_pc),
    .if_predicted (if_predicted),
    .ex_valid     (ex_valid),
    .ex_stall     (ex_stall),
    .ex_pc        (ex_pc),
    .ex_predicted (ex_predicted),
    .ex_actual    (ex_actual),
    .redirect     (redirect),
    .redirect_tgt (redirect_tgt),
    .pred_correct (pred_correct)
`ifdef BHC_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // One firing update; returns #1 after the capturing edge with ex_valid dropped.
  task automatic do_update(input logic [31:0] pc, input logic pred, input logic act);
    @(negedge clk);
    ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = pc; ex_predicted = pred; ex_actual = act;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic test_reset;
    lookup(32'h10);
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL reset_pred got %b exp 0", if_predicted); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b exp 0", redirect); end
    checks++; if (pred_correct !== 1'b0) begin errors++; $display("FAIL reset_pc got %b exp 0", pred_correct); end
    checks++; if (redirect_tgt !== 1'b0) begin errors++; $display("FAIL reset_tgt got %b exp 0", redirect_tgt); end
    do_update(32'h10, 1'b0, 1'b1);
    lookup(32'h10);
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL first_taken_pred got %b exp 1", if_predicted); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 5; i++) do_update(32'h40, 1'b0, 1'b1);
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL sat_st_pred got %b exp 1", if_predicted); end
    do_update(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL sat_st_to_wt got %b exp 1", if_predicted); end
    do_update(32'h40, 1'b1, 1'b0);
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL sat_wt_to_wnt got %b exp 0", if_predicted); end
    for (int i = 0; i < 4; i++) do_update(32'h40, 1'b0, 1'b0);
    do_update(32'h40, 1'b0, 1'b1);
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL sat_no_underflow got %b exp 0", if_predicted); end
    do_update(32'h40, 1'b0, 1'b1);
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL sat_climb got %b exp 1", if_predicted); end
  endtask

  task automatic test_compare;
    do_update(32'hC0, 1'b0, 1'b1);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL cmp_nt_t_redirect got %b exp 1", redirect); end
    checks++; if (redirect_tgt !== 1'b0) begin errors++; $display("FAIL cmp_nt_t_tgt got %b exp 0", redirect_tgt); end
    checks++; if (pred_correct !== 1'b0) begin errors++; $display("FAIL cmp_nt_t_pc got %b exp 0", pred_correct); end
    @(posedge clk); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL cmp_idle_redirect got %b exp 0", redirect); end
    checks++; if (redirect_tgt !== 1'b0) begin errors++; $display("FAIL cmp_idle_tgt_hold got %b exp 0", redirect_tgt); end
    do_update(32'hC0, 1'b1, 1'b0);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL cmp_t_nt_redirect got %b exp 1", redirect); end
    checks++; if (redirect_tgt !== 1'b1) begin errors++; $display("FAIL cmp_t_nt_tgt got %b exp 1", redirect_tgt); end
    do_update(32'hC0, 1'b1, 1'b1);
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL cmp_ok_redirect got %b exp 0", redirect); end
    checks++; if (pred_correct !== 1'b1) begin errors++; $display("FAIL cmp_ok_pc got %b exp 1", pred_correct); end
    checks++; if (redirect_tgt !== 1'b1) begin errors++; $display("FAIL cmp_ok_tgt got %b exp 1", redirect_tgt); end
    @(posedge clk); #1;
    checks++; if (pred_correct !== 1'b0) begin errors++; $display("FAIL cmp_pc_pulse_width got %b exp 0", pred_correct); end
  endtask

  task automatic test_bypass;
    @(negedge clk);
    if_pc = 32'h80; ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = 32'h80; ex_predicted = 1'b0; ex_actual = 1'b1;
    #1;
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL bypass_taken got %b exp 1", if_predicted); end
    ex_pc = 32'h84;
    #1;
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL bypass_other_idx got %b exp 0", if_predicted); end
    ex_pc = 32'h80;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    lookup(32'h80);
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL bypass_written got %b exp 1", if_predicted); end
    @(negedge clk);
    ex_valid = 1'b1; ex_actual = 1'b0; ex_predicted = 1'b1;
    #1;
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL bypass_nt got %b exp 0", if_predicted); end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic test_stall;
    @(negedge clk);
    if_pc = 32'h100; ex_valid = 1'b1; ex_stall = 1'b1; ex_pc = 32'h100; ex_predicted = 1'b0; ex_actual = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (redirect !== 1'b0 || pred_correct !== 1'b0) begin
        errors++; $display("FAIL stall_pulse cyc %0d got %b%b exp 00", i, redirect, pred_correct);
      end
      checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL stall_entry cyc %0d got %b exp 0", i, if_predicted); end
    end
    @(negedge clk);
    ex_stall = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL stall_release_redirect got %b exp 1", redirect); end
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL stall_release_entry got %b exp 1", if_predicted); end
    @(posedge clk); #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_single_pulse got %b exp 0", redirect); end
    do_update(32'h100, 1'b1, 1'b0);
    lookup(32'h100);
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL stall_single_update got %b exp 0", if_predicted); end
  endtask

  task automatic test_reset_midrun;
    do_update(32'h40, 1'b1, 1'b1);
    do_update(32'h40, 1'b1, 1'b1);
    do_update(32'h40, 1'b0, 1'b1);
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL mid_pre_redirect got %b exp 1", redirect); end
    reset = 1'b1;
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL mid_redirect_clear got %b exp 0", redirect); end
    @(negedge clk);
    reset = 1'b0;
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL mid_entry_wnt got %b exp 0", if_predicted); end
    lookup(32'h80);
    checks++; if (if_predicted !== 1'b0) begin errors++; $display("FAIL mid_other_entry got %b exp 0", if_predicted); end
    do_update(32'h40, 1'b0, 1'b1);
    lookup(32'h40);
    checks++; if (if_predicted !== 1'b1) begin errors++; $display("FAIL mid_wnt_not_snt got %b exp 1", if_predicted); end
  endtask

`ifdef BHC_STATS_EN
  task automatic test_stats;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    checks++; if (stat_branches !== 32'd0) begin errors++; $display("FAIL stats_reset got %0d exp 0", stat_branches); end
    for (int i = 0; i < 10; i++) do_update(32'h200 + 32'(i * 4), 1'b0, (i < 3) ? 1'b1 : 1'b0);
    checks++; if (stat_branches !== 32'd10) begin errors++; $display("FAIL stats_branches got %0d exp 10", stat_branches); end
    checks++; if (stat_mispredicts !== 32'd3) begin errors++; $display("FAIL stats_mispredicts got %0d exp 3", stat_mispredicts); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; if_pc = '0; ex_valid = 1'b0; ex_stall = 1'b0;
    ex_pc = '0; ex_predicted = 1'b0; ex_actual = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_saturation;
    test_compare;
    test_bypass;
    test_stall;
    test_reset_midrun;
`ifdef BHC_STATS_EN
    test_stats;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
